// File: rtl/gpc_mem_responder.sv
// gpc_mem_responder
//   Memory responder for a small CPU. After reset it sits in LOAD, taking a
//   byte stream from a loader into the program store. The byte flagged
//   load_last ends loading, and the CPU is released into RUN. In RUN the CPU
//   reads and writes RAM (0x0000-0x7FFF, aliased) and the program store
//   (0x8000-0xFFFF, aliased) over a shared bidirectional data bus.
//
//   Config macro: GPC_MEM_WPROT_EN -- when defined, CPU writes to the
//   program store are dropped, so only the loader can modify it.
//
// Ports
//   clk, rst_n    clock; synchronous active-low reset
//   address, rw   CPU bus address and direction (1 = CPU writes)
//   data          shared CPU data bus; driven only in RUN while rw = 0
//   load_valid    loader byte valid
//   load_data     loader byte
//   load_last     marks the final loader byte
//   load_ready    loader handshake; high in LOAD
//   cpu_run       high in RUN
//   load_ovf      sticky flag: the load pointer wrapped around
module gpc_mem_responder #(
  parameter int RAM_AW = 10,
  parameter int ROM_AW = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] address,
  input  logic        rw,
  inout  wire  [7:0]  data,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_run,
  output logic        load_ovf
);

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t            r_state;
  logic [ROM_AW-1:0] r_load_ptr;
  logic              r_load_ovf;
  logic              r_load_ready;
  logic              r_cpu_run;
  logic [7:0]        r_rd_data;

  // Neither memory has a reset; the contents survive reset.
  logic [7:0] r_ram [0:(1<<RAM_AW)-1];
  logic [7:0] r_rom [0:(1<<ROM_AW)-1];

  logic [RAM_AW-1:0] w_ram_addr;
  logic [ROM_AW-1:0] w_rom_addr;
  logic              w_load_acc;
  logic              w_cpu_wr;
  logic              w_ram_we;
  logic              w_rom_cpu_we;
  logic              w_rom_we;
  logic [ROM_AW-1:0] w_rom_waddr;
  logic [7:0]        w_rom_wdata;
  logic              w_unused;

  // The upper address bits are dropped, so each region aliases across its
  // half of the address map.
  assign w_ram_addr = address[RAM_AW-1:0];
  assign w_rom_addr = address[ROM_AW-1:0];
  assign w_unused   = &{1'b0, address};

  assign w_load_acc = (r_state == S_LOAD) && load_valid;
  assign w_cpu_wr   = (r_state == S_RUN) && rw;
  assign w_ram_we   = rst_n && w_cpu_wr && !address[15];

`ifdef GPC_MEM_WPROT_EN
  assign w_rom_cpu_we = 1'b0;
`else
  assign w_rom_cpu_we = rst_n && w_cpu_wr && address[15];
`endif

  // The loader and the CPU are separated by state, so they never contend
  // for the program-store write port.
  assign w_rom_we    = (rst_n && w_load_acc) || w_rom_cpu_we;
  assign w_rom_waddr = (r_state == S_LOAD) ? r_load_ptr : w_rom_addr;
  assign w_rom_wdata = (r_state == S_LOAD) ? load_data  : data;

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_addr]  <= data;
    if (w_rom_we) r_rom[w_rom_waddr] <= w_rom_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_LOAD;
      r_load_ptr   <= '0;
      r_load_ovf   <= 1'b0;
      r_load_ready <= 1'b1;
      r_cpu_run    <= 1'b0;
      r_rd_data    <= 8'h00;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (load_valid) begin
            r_load_ptr <= r_load_ptr + ROM_AW'(1);
            // The pointer wraps naturally; the flag records that it happened.
            if (&r_load_ptr) r_load_ovf <= 1'b1;
            if (load_last) begin
              r_state      <= S_RUN;
              r_load_ready <= 1'b0;
              r_cpu_run    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!rw)
            r_rd_data <= address[15] ? r_rom[w_rom_addr] : r_ram[w_ram_addr];
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // The bus enable follows rw combinationally, so the responder releases
  // the bus in the same cycle the CPU starts driving it.
  assign data = (r_state == S_RUN && !rw) ? r_rd_data : 8'hzz;

  assign load_ready = r_load_ready;
  assign cpu_run    = r_cpu_run;
  assign load_ovf   = r_load_ovf;

endmodule

// File: tb/tb_gpc_mem_responder.sv
// Bench for gpc_mem_responder: directed vectors followed by random CPU
// traffic. Results are compared against a behavioural model built from
// plain arrays, a pointer and a state flag.
module tb_gpc_mem_responder;
  localparam int RAM_AW = 10;
  localparam int ROM_AW = 10;
  localparam int RAMSZ  = 1 << RAM_AW;
  localparam int ROMSZ  = 1 << ROM_AW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] address;
  logic        rw;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready, cpu_run, load_ovf;
  logic [7:0]  tb_d;
  logic        tb_drv;
  wire  [7:0]  data;

  assign data = tb_drv ? tb_d : 8'hzz;

  always #5 clk = ~clk;

  gpc_mem_responder #(.RAM_AW(RAM_AW), .ROM_AW(ROM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .rw(rw), .data(data),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .cpu_run(cpu_run), .load_ovf(load_ovf)
  );

  // reference model
  logic [7:0] m_ram [RAMSZ];
  logic [7:0] m_rom [ROMSZ];
  bit         m_ram_ok [RAMSZ];
  bit         m_rom_ok [ROMSZ];
  bit         m_run;
  int         m_ptr;
  bit         m_ovf;
  logic [7:0] m_rd;
  bit         m_rd_ok;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, and advance the model.
  task automatic cyc(input bit rst, input bit v, input logic [7:0] d, input bit last,
                     input logic [15:0] a, input bit w, input logic [7:0] wd);
    rst_n = rst; load_valid = v; load_data = d; load_last = last;
    address = a; rw = w; tb_d = wd; tb_drv = w;
    @(posedge clk);
    if (!rst) begin
      m_run = 0; m_ptr = 0; m_ovf = 0; m_rd = 8'h00; m_rd_ok = 1;
    end else if (!m_run) begin
      if (v) begin
        m_rom[m_ptr] = d; m_rom_ok[m_ptr] = 1;
        if (m_ptr == ROMSZ - 1) m_ovf = 1;
        m_ptr = (m_ptr + 1) % ROMSZ;
        if (last) m_run = 1;
      end
    end else if (w) begin
      if (a[15]) begin
`ifndef GPC_MEM_WPROT_EN
        m_rom[int'(a) % ROMSZ] = wd; m_rom_ok[int'(a) % ROMSZ] = 1;
`endif
      end else begin
        m_ram[int'(a) % RAMSZ] = wd; m_ram_ok[int'(a) % RAMSZ] = 1;
      end
    end else if (a[15]) begin
      m_rd = m_rom[int'(a) % ROMSZ]; m_rd_ok = m_rom_ok[int'(a) % ROMSZ];
    end else begin
      m_rd = m_ram[int'(a) % RAMSZ]; m_rd_ok = m_ram_ok[int'(a) % RAMSZ];
    end
    #1;
  endtask

  task automatic chk_st(input string tag);
    chk({tag, "_run"}, {31'd0, cpu_run}, {31'd0, m_run});
    chk({tag, "_rdy"}, {31'd0, load_ready}, {31'd0, !m_run});
    chk({tag, "_ovf"}, {31'd0, load_ovf}, {31'd0, m_ovf});
  endtask

  task automatic ld(input logic [7:0] d, input bit last);
    cyc(1, 1, d, last, 16'h0000, 0, 8'h00);
  endtask

  task automatic rd(input string tag, input logic [15:0] a);
    cyc(1, 0, 8'h00, 0, a, 0, 8'h00);
    if (m_rd_ok) chk(tag, {24'd0, data}, {24'd0, m_rd});
  endtask

  // While the bench drives a write, the bus must carry exactly the bench's byte.
  task automatic wr(input string tag, input logic [15:0] a, input logic [7:0] wd);
    cyc(1, 0, 8'h00, 0, a, 1, wd);
    chk(tag, {24'd0, data}, {24'd0, wd});
  endtask

  initial begin
    int acc;
    tb_drv = 0; tb_d = 0; rst_n = 0; address = 0; rw = 0;
    load_valid = 0; load_data = 0; load_last = 0;
    m_run = 0; m_ptr = 0; m_ovf = 0; m_rd = 0; m_rd_ok = 1;

    cyc(0, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    cyc(0, 1, 8'hEE, 1, 16'h0000, 0, 8'h00);
    chk_st("reset");

    // three-byte program
    ld(8'h02, 0); chk_st("ld0");
    ld(8'h55, 0); chk_st("ld1");
    ld(8'h00, 1); chk_st("ld2");
    chk("rd_reg_reset", {24'd0, data}, 32'h00);
    rd("r8000", 16'h8000); chk("r8000_k", {24'd0, data}, 32'h02);
    rd("r8001", 16'h8001); chk("r8001_k", {24'd0, data}, 32'h55);
    rd("r8002", 16'h8002); chk("r8002_k", {24'd0, data}, 32'h00);
    cyc(1, 1, 8'hFF, 1, 16'h8001, 0, 8'h00);
    chk_st("run_ignores_load");

    // last write wins, and the RAM alias reads the same cell
    wr("w7fff_a", 16'h7FFF, 8'h12);
    wr("w7fff_b", 16'h7FFF, 8'h34);
    rd("r7fff", 16'h7FFF); chk("r7fff_k", {24'd0, data}, 32'h34);
    rd("r03ff", 16'h03FF); chk("r03ff_k", {24'd0, data}, 32'h34);

    // program-store write from the CPU
    wr("w8000", 16'h8000, 8'hAA);
    rd("r8000_wp", 16'h8000);
`ifdef GPC_MEM_WPROT_EN
    chk("wprot_k", {24'd0, data}, 32'h02);
`else
    chk("wprot_k", {24'd0, data}, 32'hAA);
`endif

    // random CPU traffic over a small aliased pool of locations
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      a = 16'(($urandom_range(0, 1) << 15) | ($urandom_range(0, 31) << 10) | $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        rw = 1;
        cyc(1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), a, 1, 8'($urandom));
        chk("rnd_wr_bus", {24'd0, data}, {24'd0, tb_d});
      end else begin
        cyc(1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), a, 0, 8'h00);
        if (m_rd_ok) chk("rnd_rd", {24'd0, data}, {24'd0, m_rd});
      end
      if (i % 50 == 0) chk_st("rnd_st");
    end

    // reset part-way through a load
    cyc(0, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    chk_st("rst2");
    ld(8'h11, 0); ld(8'h22, 0);
    cyc(0, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    chk_st("rst_mid");
    ld(8'h99, 1); chk_st("reload");
    rd("r8000_99", 16'h8000); chk("r8000_99_k", {24'd0, data}, 32'h99);
    rd("r8001_22", 16'h8001);

    // load 2^ROM_AW+1 bytes with random gaps; the last byte wraps onto 0x8000
    cyc(0, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    acc = 0;
    while (acc < ROMSZ + 1) begin
      bit v;
      logic [7:0] b;
      v = ($urandom_range(0, 3) != 0);
      b = (acc == ROMSZ) ? 8'h77 : 8'($urandom);
      cyc(1, v, b, (acc == ROMSZ), 16'h0000, 0, 8'h00);
      if (v) acc++;
      chk_st("ovf_ld");
    end
    chk("ovf_flag", {31'd0, load_ovf}, 32'd1);
    rd("r8000_77", 16'h8000); chk("r8000_77_k", {24'd0, data}, 32'h77);
    rd("r8001_ovf", 16'h8001);
    rd("r83ff_ovf", 16'h83FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
